// File: rtl/libv_pkg.sv
// Shared library package: constants and small helpers used across libv stream blocks.
package libv_pkg;

    localparam int unsigned LIBV_SKID_DEPTH = 2;
    localparam int unsigned LIBV_MAX_N      = 32;

    // True when at most one bit of v is set; narrower vectors are zero-extended by the caller.
    function automatic logic is_onehot0(input logic [LIBV_MAX_N-1:0] v);
        return ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/libv_stream_demux_if.sv
// Handshake bundle of the stream demux: one producer-side stream and N consumer-side streams.
interface libv_stream_demux_if #(
    parameter int N = 4,
    parameter int W = 32
);
    logic                  in_vld;
    logic [N-1:0]          in_sel;
    logic [W-1:0]          in_w;
    logic                  in_rdy;
    logic [N-1:0]          out_vld;
    logic [N-1:0][W-1:0]   out_w;
    logic [N-1:0]          out_rdy;
    logic                  err_sel;

    modport master (
        output in_vld, in_sel, in_w, out_rdy,
        input  in_rdy, out_vld, out_w, err_sel
    );

    modport slave (
        input  in_vld, in_sel, in_w, out_rdy,
        output in_rdy, out_vld, out_w, err_sel
    );
endinterface

// File: rtl/libv_stream_demux_chk.sv
// Protocol checkers for the 2-entry skid buffer and the demux push decode.
module libv_stream_skid2_chk
    import libv_pkg::*;
#(
    parameter int W = 32
) (
    input logic         clk,
    input logic         arst_n,
    input logic [1:0]   cnt,
    input logic         push,
    input logic         full,
    input logic         out_vld,
    input logic         out_rdy,
    input logic [W-1:0] out_w
);
    a_cnt_max: assert property (@(posedge clk) disable iff (!arst_n) cnt <= 2'd2);
    a_no_push_full: assert property (@(posedge clk) disable iff (!arst_n) !(push && full));
    a_head_stable: assert property (@(posedge clk) disable iff (!arst_n)
        (out_vld && !out_rdy) |=> $stable(out_w));
endmodule

module libv_stream_demux_chk
    import libv_pkg::*;
#(
    parameter int N = 4
) (
    input logic         clk,
    input logic         arst_n,
    input logic         in_vld,
    input logic         in_rdy,
    input logic [N-1:0] in_sel,
    input logic [N-1:0] push,
    input logic [N-1:0] rdy,
    input logic [N-1:0] full,
    input logic [N-1:0] empty
);
    // A broadcast lands in every selected channel or in none of them.
    a_atomic: assert property (@(posedge clk) disable iff (!arst_n)
        push == ((in_vld && in_rdy) ? in_sel : {N{1'b0}}));
    a_rdy_full: assert property (@(posedge clk) disable iff (!arst_n) rdy == ~full);

    for (genvar i = 0; i < N; i++) begin : g_state
        a_full_empty: assert property (@(posedge clk) disable iff (!arst_n)
            is_onehot0({{(LIBV_MAX_N-2){1'b0}}, full[i], empty[i]}));
    end
endmodule

// File: rtl/libv_stream_skid2.sv
// Two-entry FIFO with valid/ready on both sides; full/empty are registered so the
// upstream ready never depends combinationally on the downstream ready.
module libv_stream_skid2
    import libv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_w,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_w,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem_r [LIBV_SKID_DEPTH];
    logic         wptr_r;
    logic         rptr_r;
    logic [1:0]   cnt_r;
    logic [1:0]   cnt_nxt_s;
    logic         full_r;
    logic         empty_r;
    logic         push_s;
    logic         pop_s;

    assign push_s  = in_vld & ~full_r;
    assign pop_s   = out_rdy & ~empty_r;
    assign in_rdy  = ~full_r;
    assign out_vld = ~empty_r;
    assign out_w   = mem_r[rptr_r];
    assign full    = full_r;
    assign empty   = empty_r;

    // Next occupancy; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + 2'd1;
            2'b01:   cnt_nxt_s = cnt_r - 2'd1;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Storage, pointers and occupancy flags.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < LIBV_SKID_DEPTH; k++) begin
                mem_r[k] <= {W{1'b0}};
            end
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            cnt_r   <= 2'd0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wptr_r] <= in_w;
                wptr_r        <= ~wptr_r;
            end
            if (pop_s) begin
                rptr_r <= ~rptr_r;
            end
            cnt_r   <= cnt_nxt_s;
            full_r  <= (cnt_nxt_s == 2'd2);
            empty_r <= (cnt_nxt_s == 2'd0);
        end
    end

    libv_stream_skid2_chk #(.W(W)) u_chk (
        .clk     (clk),
        .arst_n  (arst_n),
        .cnt     (cnt_r),
        .push    (in_vld),
        .full    (full_r),
        .out_vld (~empty_r),
        .out_rdy (out_rdy),
        .out_w   (out_w)
    );
endmodule

// File: rtl/libv_stream_demux.sv
// One-hot steered stream demux: one producer fans out to N buffered consumers;
// multi-hot selects broadcast, an all-zero select drops the beat and flags err_sel.
module libv_stream_demux #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 arst_n,
    libv_stream_demux_if.slave   bus
);
    logic [N-1:0]        full_s;
    logic [N-1:0]        empty_s;
    logic [N-1:0]        rdy_s;
    logic [N-1:0]        push_s;
    logic [N-1:0]        vld_s;
    logic [N-1:0][W-1:0] w_s;
    logic                sel_none_s;
    logic                in_rdy_s;
    logic                accept_s;
    logic                err_sel_r;

    // Ready depends only on the select and registered fullness, never on out_rdy.
    assign sel_none_s = (bus.in_sel == {N{1'b0}});
    assign in_rdy_s   = sel_none_s | (&(~bus.in_sel | ~full_s));
    assign accept_s   = bus.in_vld & in_rdy_s;

    assign bus.in_rdy  = in_rdy_s;
    assign bus.out_vld = vld_s;
    assign bus.out_w   = w_s;
    assign bus.err_sel = err_sel_r;

    // Push enables: all selected channels together, or none.
    always_comb begin
        push_s = {N{1'b0}};
        if (accept_s) begin
            push_s = bus.in_sel;
        end else begin
            push_s = {N{1'b0}};
        end
    end

    // One-cycle pulse after a beat with an empty select was swallowed.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_sel_r <= 1'b0;
        end else begin
            err_sel_r <= bus.in_vld & sel_none_s;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        libv_stream_skid2 #(.W(W)) u_skid (
            .clk     (clk),
            .arst_n  (arst_n),
            .in_vld  (push_s[i]),
            .in_rdy  (rdy_s[i]),
            .in_w    (bus.in_w),
            .out_vld (vld_s[i]),
            .out_rdy (bus.out_rdy[i]),
            .out_w   (w_s[i]),
            .full    (full_s[i]),
            .empty   (empty_s[i])
        );
    end

    libv_stream_demux_chk #(.N(N)) u_chk (
        .clk    (clk),
        .arst_n (arst_n),
        .in_vld (bus.in_vld),
        .in_rdy (in_rdy_s),
        .in_sel (bus.in_sel),
        .push   (push_s),
        .rdy    (rdy_s),
        .full   (full_s),
        .empty  (empty_s)
    );
endmodule

// File: tb/tb_libv_stream_demux.sv
// Directed and randomised self-checking bench for libv_stream_demux (N=4, W=32).
module tb_libv_stream_demux;
    localparam int N = 4;
    localparam int W = 32;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;
    logic [31:0] sbq [4][$];

    always #5 clk = ~clk;

    libv_stream_demux_if #(.N(N), .W(W)) bus ();

    libv_stream_demux #(.N(N), .W(W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [3:0] sel, input logic [31:0] w,
                         input logic [3:0] rdy);
        @(negedge clk);
        bus.in_vld  = vld;
        bus.in_sel  = sel;
        bus.in_w    = w;
        bus.out_rdy = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model step: checks current outputs, then applies this cycle's handshakes.
    task automatic observe();
        logic       er;
        logic [3:0] ev;
        er = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus.in_sel[i] && sbq[i].size() >= 2) er = 1'b0;
            ev[i] = (sbq[i].size() > 0);
        end
        chk("rnd_in_rdy", bus.in_rdy, er);
        chk("rnd_out_vld", bus.out_vld, ev);
        chk("rnd_err_sel", bus.err_sel, exp_err);
        for (int i = 0; i < 4; i++) begin
            if (ev[i] && bus.out_rdy[i]) chk("rnd_data", bus.out_w[i], sbq[i].pop_front());
        end
        if (bus.in_vld && er) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.in_sel[i]) sbq[i].push_back(bus.in_w);
            end
        end
        exp_err = bus.in_vld && (bus.in_sel == 4'b0000);
    endtask

    initial begin
        bus.in_vld  = 1'b0;
        bus.in_sel  = 4'b0000;
        bus.in_w    = 32'h0;
        bus.out_rdy = 4'b0000;
        #12;
        chk("rst_out_vld", bus.out_vld, 64'h0);
        chk("rst_err_sel", bus.err_sel, 64'h0);
        chk("rst_in_rdy", bus.in_rdy, 64'h1);
        for (int i = 0; i < 4; i++) chk("rst_out_w", bus.out_w[i], 64'h0);
        @(negedge clk);
        arst_n = 1'b1;

        // single beat to ch1
        drive(1'b1, 4'b0010, 32'hA5A5_0001, 4'b1111);
        chk("t1_in_rdy", bus.in_rdy, 64'h1);
        tick();
        chk("t1_out_vld", bus.out_vld, 64'h2);
        chk("t1_out_w1", bus.out_w[1], 64'hA5A5_0001);
        drive(1'b0, 4'b0010, 32'h0, 4'b1111);
        chk("t1_in_rdy_after", bus.in_rdy, 64'h1);
        tick();
        chk("t1_drained", bus.out_vld, 64'h0);

        // fill ch0 while stalled, then drain
        drive(1'b1, 4'b0001, 32'd1, 4'b1110);
        chk("t2_rdy_b1", bus.in_rdy, 64'h1);
        tick();
        chk("t2_vld_b1", bus.out_vld, 64'h1);
        chk("t2_w_b1", bus.out_w[0], 64'd1);
        drive(1'b1, 4'b0001, 32'd2, 4'b1110);
        chk("t2_rdy_b2", bus.in_rdy, 64'h1);
        tick();
        chk("t2_head_b2", bus.out_w[0], 64'd1);
        drive(1'b1, 4'b0001, 32'd3, 4'b1110);
        chk("t2_rdy_b3_full", bus.in_rdy, 64'h0);
        tick();
        chk("t2_head_hold", bus.out_w[0], 64'd1);
        chk("t2_vld_hold", bus.out_vld, 64'h1);
        drive(1'b1, 4'b0001, 32'd3, 4'b1111);
        chk("t2_rdy_pop_same_cycle", bus.in_rdy, 64'h0);
        tick();
        chk("t2_head_2", bus.out_w[0], 64'd2);
        chk("t2_rdy_reopen", bus.in_rdy, 64'h1);
        tick();
        chk("t2_head_3", bus.out_w[0], 64'd3);
        chk("t2_vld_3", bus.out_vld, 64'h1);
        drive(1'b0, 4'b0001, 32'd0, 4'b1111);
        tick();
        chk("t2_drained", bus.out_vld, 64'h0);

        // broadcast blocked by a full ch3
        drive(1'b1, 4'b1000, 32'h30, 4'b0111);
        tick();
        drive(1'b1, 4'b1000, 32'h31, 4'b0111);
        tick();
        chk("t3_ch3_vld", bus.out_vld, 64'h8);
        chk("t3_ch3_head", bus.out_w[3], 64'h30);
        drive(1'b1, 4'b1011, 32'h0B, 4'b0111);
        chk("t3_rdy_blocked", bus.in_rdy, 64'h0);
        tick();
        chk("t3_no_push", bus.out_vld, 64'h8);
        drive(1'b1, 4'b1011, 32'h0B, 4'b1111);
        chk("t3_rdy_still_blocked", bus.in_rdy, 64'h0);
        tick();
        chk("t3_no_push2", bus.out_vld, 64'h8);
        chk("t3_ch3_head31", bus.out_w[3], 64'h31);
        chk("t3_rdy_open", bus.in_rdy, 64'h1);
        tick();
        chk("t3_bcast_vld", bus.out_vld, 64'hB);
        chk("t3_bcast_w0", bus.out_w[0], 64'h0B);
        chk("t3_bcast_w1", bus.out_w[1], 64'h0B);
        chk("t3_bcast_w3", bus.out_w[3], 64'h0B);
        drive(1'b0, 4'b0000, 32'h0, 4'b1111);
        tick();
        chk("t3_drained", bus.out_vld, 64'h0);

        // empty select is swallowed and flagged for one cycle
        drive(1'b1, 4'b0100, 32'hC1, 4'b0000);
        tick();
        chk("t4_ch2_vld", bus.out_vld, 64'h4);
        drive(1'b1, 4'b0000, 32'hDEAD, 4'b0000);
        chk("t4_rdy", bus.in_rdy, 64'h1);
        chk("t4_err_pre", bus.err_sel, 64'h0);
        tick();
        chk("t4_err_pulse", bus.err_sel, 64'h1);
        chk("t4_vld_same", bus.out_vld, 64'h4);
        drive(1'b0, 4'b0000, 32'h0, 4'b0000);
        tick();
        chk("t4_err_clear", bus.err_sel, 64'h0);
        chk("t4_vld_same2", bus.out_vld, 64'h4);
        chk("t4_w2", bus.out_w[2], 64'hC1);

        // asynchronous reset with ch2 holding two beats
        drive(1'b1, 4'b0100, 32'hC2, 4'b0000);
        tick();
        drive(1'b0, 4'b0100, 32'h0, 4'b0000);
        chk("t5_rdy_full", bus.in_rdy, 64'h0);
        #1 arst_n = 1'b0;
        #1;
        chk("t5_rst_vld", bus.out_vld, 64'h0);
        chk("t5_rst_w2", bus.out_w[2], 64'h0);
        chk("t5_rst_rdy", bus.in_rdy, 64'h1);
        @(negedge clk);
        arst_n = 1'b1;
        drive(1'b1, 4'b0100, 32'h77, 4'b1111);
        chk("t5_rdy_after", bus.in_rdy, 64'h1);
        tick();
        chk("t5_vld_after", bus.out_vld, 64'h4);
        chk("t5_w_after", bus.out_w[2], 64'h77);
        drive(1'b0, 4'b0000, 32'h0, 4'b1111);
        tick();
        chk("t5_drained", bus.out_vld, 64'h0);

        // random traffic against the per-channel scoreboard
        exp_err = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), $urandom, 4'($urandom));
            observe();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'b0000, 32'h0, 4'b1111);
            observe();
        end
        for (int i = 0; i < 4; i++) chk("rnd_leftover", 64'(sbq[i].size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
